// File: rtl/pcie_rx_tlp_decode.sv
// pcie_rx_tlp_decode: turns the 64-bit RX TLP stream into register writes, read requests
// and 64-bit realigned completion data words.
module pcie_rx_tlp_decode #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clock_i,
  input  logic                 rst_n_i,
  input  logic                 rx_tvalid_i,
  input  logic                 rx_tlast_i,
  input  logic [63:0]          rx_tdata_i,
  output logic                 wr_valid_o,
  output logic [ADDR_BITS-1:0] wr_addr_o,
  output logic [31:0]          wr_data_o,
  output logic                 rd_valid_o,
  output logic [ADDR_BITS-1:0] rd_addr_o,
  output logic [7:0]           rd_tag_o,
  output logic [15:0]          rd_rid_o,
  output logic                 cpl_valid_o,
  output logic [7:0]           cpl_tag_o,
  output logic [63:0]          cpl_data_o,
  output logic                 cpl_last_o,
  output logic [15:0]          drop_count_o
);
  typedef enum logic [2:0] {IDLE, HDR1, WR2, CPL, DISCARD} state_e;
  state_e state_q, state_d, end_st;
  logic [1:0] fmt_q, fmt_d;
  logic [4:0] type_q, type_d;
  logic ep_q, ep_d;
  logic [9:0] len_q, len_d, cnt_q, cnt_d;
  logic [15:0] rid_q, rid_d, drop_q, drop_d;
  logic [7:0] tag_q, tag_d, rd_tag_q, rd_tag_d, cpl_tag_q, cpl_tag_d;
  logic [31:0] held_q, held_d, wr_data_q, wr_data_d;
  logic flush_q, flush_d, drop;
  logic wr_valid_q, wr_valid_d, rd_valid_q, rd_valid_d;
  logic cpl_valid_q, cpl_valid_d, cpl_last_q, cpl_last_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, beat_addr;
  logic [15:0] rd_rid_q, rd_rid_d;
  logic [63:0] cpl_data_q, cpl_data_d;
  logic is_mwr, is_mrd, is_cpl;
  assign beat_addr = rx_tdata_i[ADDR_BITS+1:2];
  assign end_st = rx_tlast_i ? IDLE : DISCARD;
  assign is_mwr = fmt_q == 2'd2 && type_q == 5'h00 && !ep_q && (len_q == 10'd1 || len_q == 10'd2);
  assign is_mrd = fmt_q == 2'd0 && type_q == 5'h00 && !ep_q && len_q == 10'd1;
  assign is_cpl = fmt_q == 2'd2 && type_q == 5'h0A && !ep_q;
  always_comb begin
    state_d = state_q;
    fmt_d = fmt_q;
    type_d = type_q;
    ep_d = ep_q;
    len_d = len_q;
    rid_d = rid_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    held_d = held_q;
    flush_d = 1'b0;
    drop = 1'b0;
    wr_valid_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_valid_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_tag_d = rd_tag_q;
    rd_rid_d = rd_rid_q;
    cpl_tag_d = cpl_tag_q;
    // A pending flush emits the odd trailing DW while IDLE consumes the next header beat
    cpl_valid_d = flush_q;
    cpl_last_d = flush_q;
    cpl_data_d = flush_q ? {32'h0, held_q} : cpl_data_q;
    if (rx_tvalid_i) begin
      unique case (state_q)
        IDLE: begin
          fmt_d = rx_tdata_i[30:29];
          type_d = rx_tdata_i[28:24];
          ep_d = rx_tdata_i[14];
          len_d = rx_tdata_i[9:0];
          rid_d = rx_tdata_i[63:48];
          tag_d = rx_tdata_i[47:40];
          drop = rx_tlast_i;
          state_d = rx_tlast_i ? IDLE : HDR1;
        end
        HDR1: begin
          if (is_mwr) begin
            wr_valid_d = 1'b1;
            wr_addr_d = beat_addr;
            wr_data_d = rx_tdata_i[63:32];
            drop = len_q == 10'd2 && rx_tlast_i;
            state_d = len_q == 10'd1 ? end_st : (rx_tlast_i ? IDLE : WR2);
          end else if (is_mrd) begin
            rd_valid_d = 1'b1;
            rd_addr_d = beat_addr;
            rd_tag_d = tag_q;
            rd_rid_d = rid_q;
            state_d = end_st;
          end else if (is_cpl) begin
            held_d = rx_tdata_i[63:32];
            cpl_tag_d = rx_tdata_i[15:8];
            cnt_d = len_q - 10'd1;
            flush_d = len_q == 10'd1;
            drop = len_q != 10'd1 && rx_tlast_i;
            state_d = len_q == 10'd1 ? end_st : (rx_tlast_i ? IDLE : CPL);
          end else begin
            drop = 1'b1;
            state_d = end_st;
          end
        end
        WR2: begin
          wr_valid_d = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          wr_data_d = rx_tdata_i[31:0];
          state_d = end_st;
        end
        CPL: begin
          cpl_valid_d = 1'b1;
          cpl_data_d = {rx_tdata_i[31:0], held_q};
          held_d = rx_tdata_i[63:32];
          cnt_d = cnt_q - 10'd2;
          cpl_last_d = cnt_q == 10'd1;
          flush_d = cnt_q == 10'd2;
          drop = cnt_q > 10'd2 && rx_tlast_i;
          state_d = cnt_q <= 10'd2 ? end_st : (rx_tlast_i ? IDLE : CPL);
        end
        default: state_d = rx_tlast_i ? IDLE : DISCARD;
      endcase
    end
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      fmt_q <= '0;
      type_q <= '0;
      ep_q <= 1'b0;
      len_q <= '0;
      rid_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      held_q <= '0;
      flush_q <= 1'b0;
      drop_q <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q <= '0;
      rd_tag_q <= '0;
      rd_rid_q <= '0;
      cpl_valid_q <= 1'b0;
      cpl_tag_q <= '0;
      cpl_data_q <= '0;
      cpl_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fmt_q <= fmt_d;
      type_q <= type_d;
      ep_q <= ep_d;
      len_q <= len_d;
      rid_q <= rid_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      held_q <= held_d;
      flush_q <= flush_d;
      drop_q <= drop_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q <= rd_addr_d;
      rd_tag_q <= rd_tag_d;
      rd_rid_q <= rd_rid_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_tag_q <= cpl_tag_d;
      cpl_data_q <= cpl_data_d;
      cpl_last_q <= cpl_last_d;
    end
  end
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_tag_o = rd_tag_q;
  assign rd_rid_o = rd_rid_q;
  assign cpl_valid_o = cpl_valid_q;
  assign cpl_tag_o = cpl_tag_q;
  assign cpl_data_o = cpl_data_q;
  assign cpl_last_o = cpl_last_q;
  assign drop_count_o = drop_q;
endmodule

// File: tb/tb_pcie_rx_tlp_decode.sv
// tb_pcie_rx_tlp_decode: scoreboard bench; a DW-level TLP model predicts strobes and drops.
module tb_pcie_rx_tlp_decode;
  localparam int AB = 10;
  logic clk = 1'b0, rst_n = 1'b0, rx_tvalid = 1'b0, rx_tlast = 1'b0;
  logic [63:0] rx_tdata = '0;
  logic wr_valid, rd_valid, cpl_valid, cpl_last;
  logic [AB-1:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [7:0] rd_tag, cpl_tag;
  logic [15:0] rd_rid, drop_count;
  logic [63:0] cpl_data;
  pcie_rx_tlp_decode #(.ADDR_BITS(AB)) dut (
    .clock_i(clk), .rst_n_i(rst_n), .rx_tvalid_i(rx_tvalid), .rx_tlast_i(rx_tlast),
    .rx_tdata_i(rx_tdata), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .rd_valid_o(rd_valid), .rd_addr_o(rd_addr), .rd_tag_o(rd_tag), .rd_rid_o(rd_rid),
    .cpl_valid_o(cpl_valid), .cpl_tag_o(cpl_tag), .cpl_data_o(cpl_data),
    .cpl_last_o(cpl_last), .drop_count_o(drop_count)
  );
  always #5 clk = ~clk;
  typedef struct {logic [AB-1:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [AB-1:0] a; logic [7:0] t; logic [15:0] r;} rd_t;
  typedef struct {logic [7:0] t; logic [63:0] d; logic l;} cpl_t;
  wr_t wr_exp[$];
  rd_t rd_exp[$];
  cpl_t cpl_exp[$];
  wr_t we;
  rd_t re;
  cpl_t ce;
  logic [31:0] tlp[$];
  int checks = 0, errors = 0, exp_drop = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (wr_valid) begin
      checks++;
      if (wr_exp.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0h data %0h, required no write", wr_addr, wr_data);
      end else begin
        we = wr_exp.pop_front();
        if (wr_addr !== we.a || wr_data !== we.d) begin
          errors++;
          $display("FAIL wr: got %0h/%0h, required %0h/%0h", wr_addr, wr_data, we.a, we.d);
        end
      end
    end
    if (rd_valid) begin
      checks++;
      if (rd_exp.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got addr %0h, required no read", rd_addr);
      end else begin
        re = rd_exp.pop_front();
        if (rd_addr !== re.a || rd_tag !== re.t || rd_rid !== re.r) begin
          errors++;
          $display("FAIL rd: got %0h/%0h/%0h, required %0h/%0h/%0h", rd_addr, rd_tag, rd_rid, re.a, re.t, re.r);
        end
      end
    end
    if (cpl_valid) begin
      checks++;
      if (cpl_exp.size() == 0) begin
        errors++;
        $display("FAIL cpl_unexpected: got %0h, required no word", cpl_data);
      end else begin
        ce = cpl_exp.pop_front();
        if (cpl_data !== ce.d || cpl_tag !== ce.t || cpl_last !== ce.l) begin
          errors++;
          $display("FAIL cpl: got %0h tag %0h last %0b, required %0h tag %0h last %0b",
                   cpl_data, cpl_tag, cpl_last, ce.d, ce.t, ce.l);
        end
      end
    end
  end
  // Predicts outputs from the DWs actually sent; tlast falls on the last beat carrying them.
  task automatic model();
    int n, beats, len, need, words;
    logic [31:0] h0, h1, h2;
    n = tlp.size();
    beats = (n + 1) / 2;
    if (beats < 2) begin
      exp_drop++;
      return;
    end
    h0 = tlp[0];
    h1 = tlp[1];
    h2 = tlp[2];
    len = (h0[9:0] == 0) ? 1024 : int'(h0[9:0]);
    if (h0[30:29] == 2 && h0[28:24] == 0 && !h0[14] && (len == 1 || len == 2)) begin
      wr_exp.push_back('{h2[AB+1:2], tlp[3]});
      if (len == 2) begin
        if (beats >= 3) wr_exp.push_back('{AB'((int'(h2[AB+1:2]) + 1) % (1 << AB)), tlp[4]});
        else exp_drop++;
      end
    end else if (h0[30:29] == 0 && h0[28:24] == 0 && !h0[14] && len == 1) begin
      rd_exp.push_back('{h2[AB+1:2], h1[15:8], h1[31:16]});
    end else if (h0[30:29] == 2 && h0[28:24] == 5'h0A && !h0[14]) begin
      need = 2 + len / 2;
      words = (beats >= need) ? (len + 1) / 2 : beats - 2;
      for (int k = 0; k < words; k++)
        cpl_exp.push_back('{h2[15:8], {(2*k+1 < len) ? tlp[4+2*k] : 32'h0, tlp[3+2*k]},
                            beats >= need && k == words - 1});
      if (beats < need) exp_drop++;
    end else exp_drop++;
  endtask
  function automatic logic [31:0] hdr(input logic [1:0] f, input logic [4:0] t, input logic e,
                                      input logic [9:0] l);
    logic [8:0] r1;
    logic [3:0] r2;
    r1 = 9'($urandom);
    r2 = 4'($urandom);
    return {1'b0, f, t, r1, e, r2, l};
  endfunction
  task automatic build(input logic [1:0] f, input logic [4:0] t, input logic e, input logic [9:0] l,
                       input logic [31:0] dw1, input logic [31:0] dw2, input int nd);
    tlp.delete();
    tlp.push_back(hdr(f, t, e, l));
    tlp.push_back(dw1);
    tlp.push_back(dw2);
    repeat (nd) tlp.push_back($urandom);
  endtask
  task automatic send(input int gap);
    int beats;
    logic [31:0] lo, hi;
    beats = (tlp.size() + 1) / 2;
    for (int i = 0; i < beats; i++) begin
      lo = tlp[2*i];
      hi = (2*i + 1 < tlp.size()) ? tlp[2*i+1] : $urandom;
      rx_tvalid = 1'b1;
      rx_tdata = {hi, lo};
      rx_tlast = (i == beats - 1);
      @(posedge clk); #1;
    end
    for (int g = 0; g < gap; g++) begin
      rx_tvalid = 1'b0;
      rx_tdata = {$urandom, $urandom};
      rx_tlast = 1'($urandom);
      @(posedge clk); #1;
    end
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
  endtask
  task automatic run(input int gap);
    model();
    send(gap);
  endtask
  task automatic idle(input int n);
    rx_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic truncate();
    int nb;
    nb = (tlp.size() + 1) / 2;
    if (nb > 1) begin
      nb = $urandom_range(1, nb - 1);
      while (tlp.size() > 2 * nb) void'(tlp.pop_back());
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_valid", wr_valid, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_cpl_last", cpl_last, 0);
    check("rst_cpl_data", cpl_data, 0);
    check("rst_drop", drop_count, 0);
    check("rst_wr_addr", wr_addr, 0);
    rst_n = 1'b1;
    idle(1);
    build(2, 0, 0, 1, 32'h0100_010F, 32'h0000_0104, 1);
    tlp[3] = 32'hCAFEF00D;
    run(2);
    check("mwr1_addr", wr_addr, 10'h041);
    check("mwr1_data", wr_data, 32'hCAFEF00D);
    build(2, 0, 0, 2, 32'h0100_020F, 32'h0000_0FFC, 2);
    tlp[3] = 32'h11111111;
    tlp[4] = 32'h22222222;
    run(2);
    check("mwr2_wrap_addr", wr_addr, 10'h000);
    build(0, 0, 0, 1, 32'h0100_2A0F, 32'h0000_0008, 0);
    run(2);
    check("mrd_addr", rd_addr, 10'h002);
    check("mrd_tag", rd_tag, 8'h2A);
    check("mrd_rid", rd_rid, 16'h0100);
    build(2, 5'h0A, 0, 4, $urandom, 32'h0100_1100, 4);
    run(0);
    build(2, 5'h0A, 0, 3, $urandom, 32'h0100_2200, 3);
    run(0);
    build(2, 0, 0, 1, $urandom, $urandom, 1);
    run(2);
    check("cpl_tag_second", cpl_tag, 8'h22);
    build(2, 5'h0A, 0, 1, $urandom, 32'h0100_3300, 1);
    run(3);
    check("drop_none", drop_count, 16'(exp_drop));
    build(3, 0, 0, 1, $urandom, $urandom, 2);
    run(1);
    build(0, 0, 0, 4, $urandom, $urandom, 0);
    run(1);
    build(2, 0, 1, 1, $urandom, $urandom, 1);
    run(1);
    build(1, 5'h10, 0, 1, $urandom, $urandom, 1);
    run(4);
    check("drop_unsupported", drop_count, 16'd4);
    build(2, 5'h0A, 0, 6, $urandom, 32'h0100_5A00, 6);
    while (tlp.size() > 4) void'(tlp.pop_back());
    tlp[3] = 32'h0;
    rx_tvalid = 1'b1;
    rx_tdata = {tlp[1], tlp[0]};
    rx_tlast = 1'b0;
    @(posedge clk); #1;
    rx_tdata = {tlp[3], tlp[2]};
    @(posedge clk); #1;
    rx_tdata = {$urandom, $urandom};
    check("pre_rst_cpl_tag", cpl_tag, 8'h5A);
    rst_n = 1'b0;
    #1;
    check("midrst_cpl_tag", cpl_tag, 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_rd_rid", rd_rid, 0);
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    rst_n = 1'b1;
    exp_drop = 0;
    idle(1);
    build(2, 0, 0, 1, $urandom, 32'h0000_0200, 1);
    tlp[3] = 32'h5EED5EED;
    run(2);
    check("post_rst_wr_addr", wr_addr, 10'h080);
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 7);
      case (k)
        0: build(2, 0, 0, 1, $urandom, $urandom, 1);
        1: build(2, 0, 0, 2, $urandom, $urandom, 2);
        2: build(0, 0, 0, 1, $urandom, $urandom, 0);
        3, 4, 7: begin
          int l;
          l = $urandom_range(1, 9);
          build(2, 5'h0A, 0, 10'(l), $urandom, $urandom, l);
          if (k == 7) truncate();
        end
        5: case ($urandom_range(0, 5))
          0: build(3, 0, 0, 1, $urandom, $urandom, 2);
          1: build(0, 0, 0, 10'($urandom_range(2, 5)), $urandom, $urandom, 0);
          2: build(2, 0, 0, 10'($urandom_range(3, 6)), $urandom, $urandom, 6);
          3: build(2, 5'h0A, 1, 2, $urandom, $urandom, 2);
          4: build(0, 5'h0A, 0, 1, $urandom, $urandom, 0);
          default: build(1, 5'h10, 0, 1, $urandom, $urandom, 1);
        endcase
        default: begin
          build(2, 0, 0, 1, $urandom, $urandom, 1);
          while (tlp.size() > 2) void'(tlp.pop_back());
        end
      endcase
      if (k != 6 && $urandom_range(0, 7) == 0) truncate();
      else if (k != 6 && $urandom_range(0, 9) == 0) begin
        tlp.push_back($urandom);
        tlp.push_back($urandom);
      end
      run($urandom_range(0, 2));
    end
    idle(10);
    check("drop_random", drop_count, 16'(exp_drop));
    check("wr_pending", wr_exp.size(), 0);
    check("rd_pending", rd_exp.size(), 0);
    check("cpl_pending", cpl_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
